// File: rtl/adc_sample_sched.sv
// Periodic ADC conversion scheduler: start pulses, 2^AVG_LOG2 sample averaging, valid/ready out.
// Define ADC_AVG_ROUND_EN for round-half-up averaging; default build floors the average.
module adc_sample_sched #(
   parameter int unsigned CANT_BITS = 13,
   parameter int unsigned PERIOD    = 5000,
   parameter int unsigned AVG_LOG2  = 2,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   output logic                        adc_start,
   input  logic                        adc_done,
   input  logic signed [CANT_BITS-1:0] adc_dato,
   output logic signed [CANT_BITS-1:0] sample_out,
   output logic                        sample_valid,
   input  logic                        sample_ready,
   output logic                        overrun,
   output logic                        timeout,
   input  logic                        clr_flags
);

   localparam int unsigned PerW  = $clog2(PERIOD);
   localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
   localparam int unsigned AccW  = CANT_BITS + AVG_LOG2;
   localparam int unsigned SumW  = AccW + 1;
   localparam int unsigned CntW  = AVG_LOG2 + 1;
   localparam int unsigned NSamp = 2 ** AVG_LOG2;
`ifdef ADC_AVG_ROUND_EN
   localparam int unsigned RndAdd = NSamp / 2;
`else
   localparam int unsigned RndAdd = 0;
`endif

   typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StWaitTick} state_e;

   state_e                      state_q, state_d;
   logic [PerW-1:0]             per_q, per_d;
   logic [ToW-1:0]              to_q, to_d;
   logic signed [AccW-1:0]      acc_q, acc_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic signed [CANT_BITS-1:0] sample_q, sample_d;
   logic                        valid_q, valid_d;
   logic                        ovr_q, ovr_d;
   logic                        tmo_q, tmo_d;
   logic                        start_q;
   logic                        load, to_evt;
   logic signed [SumW-1:0]      sum_ext;
   logic signed [CANT_BITS-1:0] avg;

   // One spare bit so the rounding offset cannot overflow the full sum.
   assign sum_ext = SumW'(acc_q) + SumW'(adc_dato);
   assign avg     = CANT_BITS'((sum_ext + $signed(SumW'(RndAdd))) >>> AVG_LOG2);

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      to_d    = to_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      to_evt  = 1'b0;
      if (state_q != StIdle) begin
         per_d = (per_q == PerW'(PERIOD - 1)) ? '0 : per_q + 1'b1;
      end
      unique case (state_q)
         StIdle: begin
            per_d = '0;
            if (enable) state_d = StStart;
         end
         StStart: begin
            to_d    = ToW'(1);
            state_d = StWaitDone;
         end
         StWaitDone: begin
            if (adc_done) begin
               to_d    = '0;
               state_d = StWaitTick;
               if (cnt_q == CntW'(NSamp - 1)) begin
                  load  = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  acc_d = AccW'(sum_ext);
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (to_q == ToW'(TIMEOUT - 1)) begin
               to_evt  = 1'b1;
               to_d    = '0;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StWaitTick;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         StWaitTick: begin
            if (per_q == PerW'(PERIOD - 1)) state_d = StStart;
         end
         default: state_d = StIdle;
      endcase
      // Dropping enable abandons any conversion and partial average.
      if (!enable && state_q != StIdle) begin
         state_d = StIdle;
         per_d   = '0;
         to_d    = '0;
         acc_d   = '0;
         cnt_d   = '0;
         load    = 1'b0;
         to_evt  = 1'b0;
      end
   end

   always_comb begin
      sample_d = sample_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      tmo_d    = tmo_q;
      if (valid_q && sample_ready) valid_d = 1'b0;
      if (clr_flags) begin
         ovr_d = 1'b0;
         tmo_d = 1'b0;
      end
      if (load) begin
         sample_d = avg;
         valid_d  = 1'b1;
         if (valid_q && !sample_ready) ovr_d = 1'b1;
      end
      if (to_evt) tmo_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         per_q    <= '0;
         to_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         tmo_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         to_q     <= to_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         tmo_q    <= tmo_d;
         start_q  <= (state_d == StStart);
      end
   end

   assign adc_start    = start_q;
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;
   assign timeout      = tmo_q;

endmodule

// File: tb/tb_adc_sample_sched.sv
// Randomized self-checking bench for adc_sample_sched against a transaction-level model.
module tb_adc_sample_sched;

   localparam int unsigned CB  = 13;
   localparam int unsigned PER = 20;
   localparam int unsigned AL  = 2;
   localparam int unsigned TO  = 10;
`ifdef ADC_AVG_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 enable = 1'b0;
   logic                 adc_done = 1'b0;
   logic signed [CB-1:0] adc_dato = '0;
   logic                 sample_ready = 1'b0;
   logic                 clr_flags = 1'b0;
   logic                 adc_start;
   logic signed [CB-1:0] sample_out;
   logic                 sample_valid;
   logic                 overrun;
   logic                 timeout;

   adc_sample_sched #(
      .CANT_BITS(CB),
      .PERIOD   (PER),
      .AVG_LOG2 (AL),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .adc_start   (adc_start),
      .adc_done    (adc_done),
      .adc_dato    (adc_dato),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .overrun     (overrun),
      .timeout     (timeout),
      .clr_flags   (clr_flags)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: start schedule, running sum of accepted samples, output/flags.
   int cyc = 0;
   bit running = 1'b0;
   int t0 = 0;
   int m_sum = 0, m_cnt = 0, m_out = 0;
   bit m_valid = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
   bit acc_ev = 1'b0, to_ev = 1'b0;
   int acc_val = 0;
   bit rand_hs = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, $signed(got), $signed(exp),
                  cyc);
      end
   endtask

   function automatic int avg_of(input int s);
      int n, q, a;
      n = 1 << AL;
      a = s + (RND != 0 ? n / 2 : 0);
      q = a / n;
      if ((a % n) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   // Apply the model for the coming edge, clock, then compare all outputs.
   task automatic step();
      bit old_v, load;
      int nv;
      load = 1'b0;
      nv   = 0;
      if (rst) begin
         running = 1'b0;
         m_sum = 0; m_cnt = 0; m_out = 0;
         m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
      end else begin
         old_v = m_valid;
         if (!enable) begin
            running = 1'b0;
            m_sum = 0; m_cnt = 0;
         end else begin
            if (!running) begin
               running = 1'b1;
               t0 = cyc + 1;
            end
            if (acc_ev) begin
               m_sum += acc_val;
               m_cnt++;
               if (m_cnt == (1 << AL)) begin
                  nv = avg_of(m_sum);
                  load = 1'b1;
                  m_sum = 0; m_cnt = 0;
               end
            end
            if (to_ev) begin
               m_sum = 0; m_cnt = 0;
            end
         end
         if (old_v && sample_ready) m_valid = 1'b0;
         if (clr_flags) begin
            m_ovr = 1'b0; m_to = 1'b0;
         end
         if (load) begin
            m_out = nv;
            m_valid = 1'b1;
            if (old_v && !sample_ready) m_ovr = 1'b1;
         end
         if (to_ev && enable) m_to = 1'b1;
      end
      acc_ev = 1'b0;
      to_ev  = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      adc_done  = 1'b0;
      clr_flags = rand_hs ? ($urandom_range(15, 0) == 0) : 1'b0;
      if (rand_hs) sample_ready = ($urandom_range(2, 0) == 0);
      check("adc_start", adc_start, 32'(running && (((cyc - t0) % PER) == 0)));
      check("sample_valid", sample_valid, m_valid);
      check("sample_out", 32'(sample_out), m_out);
      check("overrun", overrun, m_ovr);
      check("timeout", timeout, m_to);
   endtask

   task automatic wait_start();
      int i = 0;
      while (adc_start !== 1'b1 && i < 3 * PER) begin
         step();
         i++;
      end
      check("start_seen", adc_start, 1);
   endtask

   // One conversion slot: optional done after dly cycles, optional stray done afterwards.
   task automatic conv(input int v, input int dly, input bit give, input bit stray);
      wait_start();
      if (give) begin
         repeat (dly) step();
         adc_done = 1'b1;
         adc_dato = CB'(v);
         acc_ev   = 1'b1;
         acc_val  = v;
         step();
         if (stray) begin
            step();
            step();
            adc_done = 1'b1;
            adc_dato = CB'($urandom);
            step();
         end
      end else begin
         repeat (TO - 1) step();
         to_ev = 1'b1;
         step();
      end
   endtask

   task automatic consume();
      sample_ready = 1'b1;
      step();
      sample_ready = 1'b0;
      check("consumed", sample_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic signed [CB-1:0] r;
      int vals[4];

      // Reset held with enable high: nothing may start.
      rst = 1'b1;
      enable = 1'b1;
      repeat (3) step();
      check("rst_outputs", {adc_start, sample_valid, overrun, timeout, sample_out}, 0);
      rst = 1'b0;
      step();

      // Positive average.
      for (int i = 0; i < 4; i++) conv(100 + i, 3, 1'b1, 1'b0);
      check("avg_pos", 32'(sample_out), RND != 0 ? 102 : 101);
      consume();

      // Negative average, floor toward -inf.
      vals = '{-1, -1, -1, -2};
      for (int i = 0; i < 4; i++) conv(vals[i], 3, 1'b1, 1'b0);
      check("avg_neg", 32'(sample_out), RND != 0 ? -1 : -2);
      consume();

      // Overrun: two results without a consumer.
      for (int i = 0; i < 8; i++) conv(i < 4 ? 10 : 20, 2, 1'b1, 1'b0);
      check("ovr_out", 32'(sample_out), 20);
      check("ovr_valid", sample_valid, 1);
      check("ovr_flag", overrun, 1);
      clr_flags = 1'b1;
      step();
      check("ovr_cleared", overrun, 0);
      consume();

      // Timeout discards a partial average.
      conv(7, 4, 1'b1, 1'b0);
      conv(9, 5, 1'b1, 1'b0);
      conv(0, 0, 1'b0, 1'b0);
      check("tmo_flag", timeout, 1);
      for (int i = 0; i < 4; i++) conv(40 + i, 1 + i, 1'b1, 1'b0);
      check("avg_after_tmo", 32'(sample_out), RND != 0 ? 42 : 41);
      consume();
      clr_flags = 1'b1;
      step();
      check("tmo_cleared", timeout, 0);

      // Enable dropped mid-average.
      conv(500, 3, 1'b1, 1'b0);
      conv(700, 3, 1'b1, 1'b0);
      enable = 1'b0;
      repeat (3) step();
      check("idle_no_valid", sample_valid, 0);
      enable = 1'b1;
      step();
      for (int i = 0; i < 4; i++) conv(60 + i, 9, 1'b1, 1'b1);
      check("avg_after_idle", 32'(sample_out), RND != 0 ? 62 : 61);

      // Asynchronous reset while waiting for done.
      wait_start();
      step();
      step();
      rst = 1'b1;
      #1;
      check("arst_outputs", {adc_start, sample_valid, overrun, timeout, sample_out}, 0);
      repeat (2) step();
      rst = 1'b0;
      step();

      // Randomized traffic with random consumer and flag clears.
      rand_hs = 1'b1;
      for (int i = 0; i < 48; i++) begin
         if ($urandom_range(9, 0) == 0) begin
            enable = 1'b0;
            repeat (2) step();
            enable = 1'b1;
         end
         r = CB'($urandom);
         conv(int'(r), int'($urandom_range(9, 1)), $urandom_range(7, 0) != 0,
              $urandom_range(3, 0) == 0);
      end
      rand_hs = 1'b0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_sample_sched.md
Name: adc_sample_sched

Overview:
Conversion scheduler for the servo ADC path. Issues periodic start pulses to the serial ADC front end and captures each 13-bit signed result. Averages 2^AVG_LOG2 consecutive samples and hands the average to the control loop over a valid/ready handshake. Flags consumer overrun and ADC non-response.

Parameters:
CANT_BITS, 13, width of signed ADC sample in and averaged sample out
PERIOD, 5000, clk cycles between consecutive adc_start pulses (>= 4)
AVG_LOG2, 2, log2 of samples per average (0 = pass-through, max 6)
TIMEOUT, 1024, cycles to wait for adc_done after adc_start; must be <= PERIOD-2

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
enable  in  1  run request; low = idle
adc_start  out  1  one-cycle pulse requesting a conversion
adc_done  in  1  one-cycle pulse, adc_dato valid this cycle
adc_dato  in  CANT_BITS  signed sample from ADC path
sample_out  out  CANT_BITS  signed averaged sample
sample_valid  out  1  sample_out holds an unconsumed result
sample_ready  in  1  consumer accepts when valid&&ready
overrun  out  1  sticky: unconsumed result overwritten
timeout  out  1  sticky: adc_done missing within TIMEOUT
clr_flags  in  1  synchronous clear of overrun and timeout

Behaviour:
- Reset: all outputs 0; state IDLE; period counter, timeout counter, accumulator, sample count all 0.
- States: IDLE, START, WAIT_DONE, WAIT_TICK.
- IDLE: period counter held 0. enable=1 -> START next edge.
- START: adc_start=1 for exactly this cycle; period counter starts (value 0 here, increments each cycle, wraps PERIOD-1 -> 0); -> WAIT_DONE.
- WAIT_DONE: timeout counter increments from 0. adc_done=1 -> accumulate adc_dato, count+1, -> WAIT_TICK. Counter reaches TIMEOUT without adc_done -> timeout<=1, accumulator and count cleared, -> WAIT_TICK.
- WAIT_TICK: period counter wraps to 0 -> START. Start pulses therefore spaced exactly PERIOD cycles.
- adc_done outside WAIT_DONE: ignored.
- Accumulator: signed, CANT_BITS+AVG_LOG2 bits, no overflow possible.
- On the adc_done edge completing 2^AVG_LOG2 samples: sample_out <= (acc + adc_dato) >>> AVG_LOG2 (arithmetic shift, floor toward -inf); sample_valid <= 1; accumulator and count cleared. Latency: sample_valid high the cycle after adc_done.
- Handshake: valid&&ready at an edge clears sample_valid. sample_out stable while valid and not accepted.
- New result while sample_valid=1 and sample_ready=0: sample_out overwritten with newest, sample_valid stays 1, overrun<=1. If sample_ready=1 on that same edge, old result is consumed, new one loaded, no overrun.
- enable low in any non-IDLE state: -> IDLE next edge; accumulator, count and counters cleared; partial average discarded; sample_out/sample_valid retained, handshake still serviced. A conversion in flight is abandoned (its adc_done is ignored).
- clr_flags: clears overrun/timeout next edge; a set event on the same edge wins (flag stays 1).
- rst asserted mid-operation: immediate return to reset values, no adc_start glitch.

Optional Feature:
Macro ADC_AVG_ROUND_EN. Defined: average uses round-half-up, (sum + 2^(AVG_LOG2-1)) >>> AVG_LOG2, for AVG_LOG2 > 0; for AVG_LOG2 = 0 identical to undefined. Undefined: plain arithmetic shift (floor).

Test Plan:
PERIOD=20, AVG_LOG2=2, TIMEOUT=10 in all cases.
- Reset then enable=1: adc_start pulses at cycle 1 after enable, then every 20 cycles exactly. All outputs 0 while rst high.
- Averaging with done 3 cycles after each start, samples 100,101,102,103: sample_valid rises 1 cycle after the 4th done. sample_out=101 (ROUND_EN: 102).
- Negative samples -1,-1,-1,-2: sample_out=-2 (ROUND_EN: -1). sample_ready=1 clears valid next edge.
- sample_ready held 0 across 8 samples (averages 10, then 20): sample_out=20, sample_valid=1, overrun=1. clr_flags pulse -> overrun=0.
- No adc_done after a start: timeout=1 at 10 cycles after adc_start. Partial count discarded. Next adc_start still 20 cycles after the previous one.
- enable dropped after 2 of 4 samples, re-raised: state IDLE, no sample_valid. The next 4 samples alone produce the average. rst pulse mid-WAIT_DONE returns all outputs to 0.
